// File: rtl/spi_pkg.sv
// Shared constants and FSM state type for the SPI register peripheral.
`timescale 1ns/1ps
package spi_pkg;
    localparam logic [6:0] ADDR_EN_OUT_7_0  = 7'h00;
    localparam logic [6:0] ADDR_EN_OUT_15_8 = 7'h01;
    localparam logic [6:0] ADDR_EN_PWM_7_0  = 7'h02;
    localparam logic [6:0] ADDR_EN_PWM_15_8 = 7'h03;
    localparam logic [6:0] ADDR_PWM_DUTY    = 7'h04;
    localparam logic [6:0] MAX_ADDR         = 7'h04;
    localparam int         FRAME_BITS       = 16;
    localparam logic [4:0] CNT_SAT          = 5'd17;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        COMMIT
    } spi_state_e;
endpackage

// File: rtl/spi_sync.sv
// Multi-flop synchronizer for one asynchronous SPI pin, plus a history flop
// so the caller can detect edges on the synchronized value.
`timescale 1ns/1ps
module spi_sync #(
    parameter int   SYNC_STAGES = 2,
    parameter logic RESET_VAL   = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic async_i,
    output logic sync_o,
    output logic prev_o
);
    logic [SYNC_STAGES-1:0] stage_q;
    logic                   prev_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage_q <= {SYNC_STAGES{RESET_VAL}};
            prev_q  <= RESET_VAL;
        end else begin
            stage_q <= {stage_q[SYNC_STAGES-2:0], async_i};
            prev_q  <= stage_q[SYNC_STAGES-1];
        end
    end

    assign sync_o = stage_q[SYNC_STAGES-1];
    assign prev_o = prev_q;
endmodule

// File: rtl/spi_peripheral.sv
// Write-only SPI mode-0 register block: 16-bit frames {wr, addr[6:0], data[7:0]}
// update one of five output registers when chip select is released.
`timescale 1ns/1ps
module spi_peripheral #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sclk,
    input  logic       copi,
    input  logic       ncs,
    output logic [7:0] en_reg_out_7_0,
    output logic [7:0] en_reg_out_15_8,
    output logic [7:0] en_reg_pwm_7_0,
    output logic [7:0] en_reg_pwm_15_8,
    output logic [7:0] pwm_duty_cycle
);
    import spi_pkg::*;

    logic sclkSync, sclkPrev;
    logic copiSync, unusedCopiPrev;
    logic ncsSync, ncsPrev;

    spi_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
        .clk(clk), .rst_n(rst_n), .async_i(sclk), .sync_o(sclkSync), .prev_o(sclkPrev)
    );
    spi_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_copi (
        .clk(clk), .rst_n(rst_n), .async_i(copi), .sync_o(copiSync), .prev_o(unusedCopiPrev)
    );
    spi_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_ncs (
        .clk(clk), .rst_n(rst_n), .async_i(ncs), .sync_o(ncsSync), .prev_o(ncsPrev)
    );

    spi_state_e  state_q;
    logic [15:0] shift_q, shift_d;
    logic [4:0]  cnt_q, cnt_d;
    logic        ncsFall, ncsRise, sclkRise, frameOk;
    logic [6:0]  frameAddr;

    assign ncsFall   = ncsPrev & ~ncsSync;
    assign ncsRise   = ~ncsPrev & ncsSync;
    assign sclkRise  = sclkSync & ~sclkPrev;
    assign shift_d   = {shift_q[14:0], copiSync};
    assign cnt_d     = (cnt_q == CNT_SAT) ? CNT_SAT : cnt_q + 5'd1;
    assign frameAddr = shift_q[14:8];
    // Saturating at 17 lets both short and long frames fail the exact-16 test.
    assign frameOk   = (cnt_q == 5'(FRAME_BITS)) && shift_q[15] && (frameAddr <= MAX_ADDR);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= IDLE;
            shift_q         <= '0;
            cnt_q           <= '0;
            en_reg_out_7_0  <= '0;
            en_reg_out_15_8 <= '0;
            en_reg_pwm_7_0  <= '0;
            en_reg_pwm_15_8 <= '0;
            pwm_duty_cycle  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (ncsFall) begin
                        state_q <= SHIFT;
                        shift_q <= '0;
                        cnt_q   <= '0;
                    end
                end
                SHIFT: begin
                    if (ncsRise) begin
                        state_q <= COMMIT;
                    end else if (ncsFall) begin
                        shift_q <= '0;
                        cnt_q   <= '0;
                    end else if (sclkRise && !ncsSync) begin
                        shift_q <= shift_d;
                        cnt_q   <= cnt_d;
                    end
                end
                COMMIT: begin
                    state_q <= IDLE;
                    if (frameOk) begin
                        case (frameAddr)
                            ADDR_EN_OUT_7_0:  en_reg_out_7_0  <= shift_q[7:0];
                            ADDR_EN_OUT_15_8: en_reg_out_15_8 <= shift_q[7:0];
                            ADDR_EN_PWM_7_0:  en_reg_pwm_7_0  <= shift_q[7:0];
                            ADDR_EN_PWM_15_8: en_reg_pwm_15_8 <= shift_q[7:0];
                            ADDR_PWM_DUTY:    pwm_duty_cycle  <= shift_q[7:0];
                            default: ;
                        endcase
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_spi_peripheral.sv
// Self-checking bench for spi_peripheral: a register model feeds a queue of
// expected register snapshots that each scenario pops once the commit has landed.
`timescale 1ns/1ps
module tb_spi_peripheral;
    import spi_pkg::*;

    localparam int SYNC_STAGES = 2;
    localparam int HALF        = 60;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       sclk  = 1'b0;
    logic       copi  = 1'b0;
    logic       ncs   = 1'b1;
    logic [7:0] en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8, pwm_duty_cycle;

    logic [39:0] obsRegs;
    logic [39:0] modelRegs = '0;
    logic [39:0] expVal;
    logic [39:0] oldVal;
    logic [39:0] expQueue[$];
    int          assertCount = 0;
    int          failCount   = 0;

    always #5 clk = ~clk;

    spi_peripheral #(.SYNC_STAGES(SYNC_STAGES)) dut (
        .clk(clk), .rst_n(rst_n), .sclk(sclk), .copi(copi), .ncs(ncs),
        .en_reg_out_7_0(en_reg_out_7_0), .en_reg_out_15_8(en_reg_out_15_8),
        .en_reg_pwm_7_0(en_reg_pwm_7_0), .en_reg_pwm_15_8(en_reg_pwm_15_8),
        .pwm_duty_cycle(pwm_duty_cycle)
    );

    assign obsRegs = {en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8, pwm_duty_cycle};

    // Register model: snapshot packed as {out_7_0, out_15_8, pwm_7_0, pwm_15_8, duty}.
    function automatic logic [39:0] model_frame(input logic [39:0] cur, input logic [16:0] bits, input int nbits);
        logic [39:0] nxt;
        nxt = cur;
        if (nbits == 16 && bits[15] == 1'b1) begin
            case (bits[14:8])
                7'h00: nxt[39:32] = bits[7:0];
                7'h01: nxt[31:24] = bits[7:0];
                7'h02: nxt[23:16] = bits[7:0];
                7'h03: nxt[15:8]  = bits[7:0];
                7'h04: nxt[7:0]   = bits[7:0];
                default: ;
            endcase
        end
        return nxt;
    endfunction

    task automatic frame_start;
        @(posedge clk);
        #1 ncs = 1'b0;
        #(HALF);
    endtask

    task automatic shift_bits(input logic [16:0] bits, input int nbits);
        for (int i = nbits - 1; i >= 0; i--) begin
            copi = bits[i];
            #(HALF) sclk = 1'b1;
            #(HALF) sclk = 1'b0;
        end
    endtask

    task automatic frame_end;
        #(HALF);
        @(posedge clk);
        #1 ncs = 1'b1;
    endtask

    task automatic send_frame(input logic [16:0] bits, input int nbits);
        frame_start();
        shift_bits(bits, nbits);
        modelRegs = model_frame(modelRegs, bits, nbits);
        expQueue.push_back(modelRegs);
        frame_end();
    endtask

    task automatic settle;
        repeat (SYNC_STAGES + 2) @(posedge clk);
        #1;
    endtask

    task automatic pop_expected;
        expVal = (expQueue.size() > 0) ? expQueue.pop_front() : 'x;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        #23;
        assertCount++;
        if (obsRegs !== 40'h0) begin
            failCount++;
            $display("[TB] FAIL reset_regs: got %h expected %h", obsRegs, 40'h0);
        end
        assertCount++;
        if (dut.state_q !== IDLE) begin
            failCount++;
            $display("[TB] FAIL reset_state: got %0d expected %0d", dut.state_q, IDLE);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic test_write_latency;
        oldVal = modelRegs;
        frame_start();
        shift_bits(17'h080F0, 16);
        modelRegs = model_frame(modelRegs, 17'h080F0, 16);
        expQueue.push_back(modelRegs);
        frame_end();
        repeat (SYNC_STAGES + 1) @(posedge clk);
        #1;
        assertCount++;
        if (obsRegs !== oldVal) begin
            failCount++;
            $display("[TB] FAIL write_too_early: got %h expected %h", obsRegs, oldVal);
        end
        @(posedge clk);
        #1;
        pop_expected();
        assertCount++;
        if (obsRegs !== expVal) begin
            failCount++;
            $display("[TB] FAIL write_80F0: got %h expected %h", obsRegs, expVal);
        end
    endtask

    task automatic test_pwm_and_bad_addr;
        send_frame(17'h08480, 16);
        settle();
        pop_expected();
        assertCount++;
        if (obsRegs !== expVal) begin
            failCount++;
            $display("[TB] FAIL write_8480: got %h expected %h", obsRegs, expVal);
        end
        send_frame(17'h0857F, 16);
        settle();
        pop_expected();
        assertCount++;
        if (obsRegs !== expVal) begin
            failCount++;
            $display("[TB] FAIL bad_addr_857F: got %h expected %h", obsRegs, expVal);
        end
    endtask

    task automatic test_discard;
        send_frame(17'h00155, 16);
        settle();
        pop_expected();
        assertCount++;
        if (obsRegs !== expVal) begin
            failCount++;
            $display("[TB] FAIL read_0155: got %h expected %h", obsRegs, expVal);
        end
        send_frame(17'h040D5, 15);
        settle();
        pop_expected();
        assertCount++;
        if (obsRegs !== expVal) begin
            failCount++;
            $display("[TB] FAIL short_15bit: got %h expected %h", obsRegs, expVal);
        end
        send_frame(17'h10357, 17);
        settle();
        pop_expected();
        assertCount++;
        if (obsRegs !== expVal) begin
            failCount++;
            $display("[TB] FAIL long_17bit: got %h expected %h", obsRegs, expVal);
        end
        assertCount++;
        if (dut.state_q !== IDLE) begin
            failCount++;
            $display("[TB] FAIL idle_after_discard: got %0d expected %0d", dut.state_q, IDLE);
        end
    endtask

    task automatic test_reset_mid_frame;
        frame_start();
        shift_bits(17'h00083, 8);
        #(HALF / 2);
        rst_n = 1'b0;
        modelRegs = '0;
        expQueue.push_back(modelRegs);
        #20;
        pop_expected();
        assertCount++;
        if (obsRegs !== expVal) begin
            failCount++;
            $display("[TB] FAIL mid_frame_reset: got %h expected %h", obsRegs, expVal);
        end
        rst_n = 1'b1;
        #(HALF);
        @(posedge clk);
        #1 ncs = 1'b1;
        expQueue.push_back(modelRegs);
        repeat (10) @(posedge clk);
        #1;
        pop_expected();
        assertCount++;
        if (obsRegs !== expVal) begin
            failCount++;
            $display("[TB] FAIL partial_discard: got %h expected %h", obsRegs, expVal);
        end
        send_frame(17'h083AA, 16);
        settle();
        pop_expected();
        assertCount++;
        if (obsRegs !== expVal) begin
            failCount++;
            $display("[TB] FAIL write_83AA: got %h expected %h", obsRegs, expVal);
        end
    endtask

    task automatic test_back_to_back;
        frame_start();
        shift_bits(17'h08201, 16);
        modelRegs = model_frame(modelRegs, 17'h08201, 16);
        expQueue.push_back(modelRegs);
        frame_end();
        // ncs stays high for exactly two clk samples before the next frame.
        @(posedge clk);
        @(posedge clk);
        #1 ncs = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        pop_expected();
        assertCount++;
        if (obsRegs !== expVal) begin
            failCount++;
            $display("[TB] FAIL b2b_first_8201: got %h expected %h", obsRegs, expVal);
        end
        #(HALF);
        shift_bits(17'h08202, 16);
        modelRegs = model_frame(modelRegs, 17'h08202, 16);
        expQueue.push_back(modelRegs);
        frame_end();
        settle();
        pop_expected();
        assertCount++;
        if (obsRegs !== expVal) begin
            failCount++;
            $display("[TB] FAIL b2b_second_8202: got %h expected %h", obsRegs, expVal);
        end
    endtask

    initial begin
        test_reset();
        test_write_latency();
        test_pwm_and_bad_addr();
        test_discard();
        test_reset_mid_frame();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog expired");
    end
endmodule

// File: doc/spi_peripheral.md
SPI_PERIPHERAL -- requirements
Module: spi_peripheral

Interface
REQ-001 Parameter SYNC_STAGES, 2: metastability flops per asynchronous SPI input; legal values 2 or 3.
REQ-002 clk  input  1  system clock; all state changes on its rising edge.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 sclk  input  1  SPI clock from controller, asynchronous to clk (mode 0).
REQ-005 copi  input  1  SPI data, controller to peripheral, asynchronous to clk.
REQ-006 ncs  input  1  SPI chip select, active low, asynchronous to clk.
REQ-007 en_reg_out_7_0  output  8  register 0x00: output enables uo_out[7:0].
REQ-008 en_reg_out_15_8  output  8  register 0x01: output enables uio_out[7:0].
REQ-009 en_reg_pwm_7_0  output  8  register 0x02: PWM select uo_out[7:0].
REQ-010 en_reg_pwm_15_8  output  8  register 0x03: PWM select uio_out[7:0].
REQ-011 pwm_duty_cycle  output  8  register 0x04: PWM duty, consumed by the PWM stage.

Function
REQ-012 sclk, copi, ncs SHALL each pass through SYNC_STAGES flops plus one history flop; all edge detection uses synchronized values only.
REQ-013 Frame: 16 bits, MSB first; bit15 = R/W (1 write), bits14:8 = 7-bit address, bits7:0 = data.
REQ-014 copi SHALL be captured on each synchronized sclk rising edge while synchronized ncs is low; sclk edges with ncs high are ignored.
REQ-015 FSM states IDLE, SHIFT, COMMIT; IDLE->SHIFT on synchronized ncs falling edge (clears shift register and 5-bit bit counter); SHIFT->COMMIT on synchronized ncs rising edge; COMMIT->IDLE after one cycle.
REQ-016 In COMMIT, the addressed register SHALL be written only if bit count == 16, bit15 == 1 and address <= 0x04; otherwise no register changes.
REQ-017 Bit counter SHALL saturate at 17; any frame with more than 16 or fewer than 16 captured bits is discarded.
REQ-018 Read frames (bit15 == 0) SHALL be discarded; no data is driven back.
REQ-019 A new ncs falling edge during SHIFT (glitch) SHALL restart the frame from zero bits.
REQ-020 Register update SHALL be visible on outputs exactly SYNC_STAGES+2 clk rising edges after the first clk edge sampling ncs high.
REQ-021 Outputs SHALL be registered, change only in COMMIT, and hold value otherwise.
REQ-022 Correct capture is required for sclk high and low phases each >= SYNC_STAGES+2 clk periods.

Reset
REQ-023 rst_n low SHALL immediately force FSM to IDLE, bit counter and shift register to 0, all five output registers to 0x00, synchronizer flops to ncs=1, sclk=0, copi=0.
REQ-024 Reset asserted mid-frame SHALL discard the frame; after release, the block waits for a fresh ncs falling edge.

Structure
REQ-025 Shared package spi_pkg SHALL hold register address constants (0x00..0x04), MAX_ADDR, FRAME_BITS = 16, and the FSM state enum.
REQ-026 One sub-module spi_sync SHALL implement the parameterized synchronizer plus history flop, instantiated once per SPI input.

Verification
REQ-027 After reset -> all five outputs 0x00, FSM IDLE.
REQ-028 Write frame 0x80F0 (addr 0x00, data 0xF0) -> en_reg_out_7_0 = 0xF0 at REQ-020 latency; others unchanged.
REQ-029 Write 0x8480 -> pwm_duty_cycle = 0x80; then write 0x857F (addr 0x05) -> all registers unchanged.
REQ-030 Read frame 0x0155 -> no register changes; 15-bit frame and 17-bit frame to addr 0x01 -> en_reg_out_15_8 stays 0x00.
REQ-031 rst_n pulsed low after 8 bits of 0x83AA -> en_reg_pwm_15_8 = 0x00; next full 0x83AA -> 0xAA.
REQ-032 Back-to-back writes 0x8201 then 0x8202 with two-cycle ncs-high gap -> en_reg_pwm_7_0 = 0x01 then 0x02.
